reg_wb_queue: RTL

- Writeback-side driver of the register file write port (REG_write_1 / REG_address_wr / REG_data_wb_in1).
- Accepts results from two producers (A = memory/multicycle unit, older; B = ALU, younger) over valid/ready handshakes.
- Buffers results in a DEPTH-entry in-order FIFO and retires at most one register write per cycle.
- Offers pending-data lookup so decode can see writes that have not yet retired.

---
 rtl/reg_wb_pkg.sv | 14 +
 rtl/reg_wb_fifo.sv | 58 +++++
 rtl/reg_wb_queue.sv | 102 ++++++++++
 3 files changed

// File: rtl/reg_wb_pkg.sv
// Shared types and defaults for the register writeback queue.
package reg_wb_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 6;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
   } wb_entry_t;

   localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/reg_wb_fifo.sv
// In-order writeback FIFO: up to two pushes and one pop per cycle, plus an
// age-ordered view of all slots (index 0 is the head) for forwarding.
module reg_wb_fifo
   import reg_wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_push0,
   input  wb_entry_t              i_entry0,
   input  logic                   i_push1,
   input  wb_entry_t              i_entry1,
   input  logic                   i_pop,
   output wb_entry_t              o_head,
   output logic [$clog2(DEPTH):0] o_count,
   output wb_entry_t [DEPTH-1:0]  o_entries
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   wb_entry_t     r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [PW-1:0] w_wptr1;

   // The second push lands behind the first only when the first one is present.
   assign w_wptr1 = r_wptr + PW'(i_push0);

   always_ff @(posedge i_clk) begin
      if (i_push0) r_mem[r_wptr] <= i_entry0;
      if (i_push1) r_mem[w_wptr1] <= i_entry1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         r_wptr  <= r_wptr + PW'(i_push0) + PW'(i_push1);
         r_rptr  <= r_rptr + PW'(i_pop);
         r_count <= r_count + CW'(i_push0) + CW'(i_push1) - CW'(i_pop);
      end
   end

   assign o_head  = r_mem[r_rptr];
   assign o_count = r_count;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         o_entries[i] = r_mem[r_rptr + PW'(i)];
      end
   end

endmodule

// File: rtl/reg_wb_queue.sv
// Register-file writeback queue: two producers, one retire per cycle.
// Pending-write forwarding is built only when REG_WB_QUEUE_FWD_EN is defined.
module reg_wb_queue
   import reg_wb_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                   SYS_clk,
   input  logic                   SYS_rst_n,
   input  logic                   WBA_valid,
   output logic                   WBA_ready,
   input  logic [ADDR_W-1:0]      WBA_addr,
   input  logic [DATA_W-1:0]      WBA_data,
   input  logic                   WBB_valid,
   output logic                   WBB_ready,
   input  logic [ADDR_W-1:0]      WBB_addr,
   input  logic [DATA_W-1:0]      WBB_data,
   output logic                   REG_write_1,
   output logic [ADDR_W-1:0]      REG_address_wr,
   output logic [DATA_W-1:0]      REG_data_wb_in1,
   input  logic [ADDR_W-1:0]      FWD_addr1,
   output logic                   FWD_hit1,
   output logic [DATA_W-1:0]      FWD_data1,
   input  logic [ADDR_W-1:0]      FWD_addr2,
   output logic                   FWD_hit2,
   output logic [DATA_W-1:0]      FWD_data2,
   output logic [$clog2(DEPTH):0] WB_count,
   output logic                   WB_empty
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic                  w_push0;
   logic                  w_push1;
   logic                  w_pop;
   logic                  w_nonempty;
   logic [CW-1:0]         w_count;
   wb_entry_t             w_head;
   wb_entry_t [DEPTH-1:0] w_entries;

   // Space is judged on the registered count only; a same-cycle pop frees nothing.
   assign WBA_ready = w_count < CW'(DEPTH);
   assign WBB_ready = (w_count + CW'(WBA_valid & WBA_ready)) < CW'(DEPTH);

   assign w_push0    = WBA_valid & WBA_ready & (WBA_addr != REG_ZERO);
   assign w_push1    = WBB_valid & WBB_ready & (WBB_addr != REG_ZERO);
   assign w_nonempty = w_count != '0;
   assign w_pop      = w_nonempty;

   reg_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk     (SYS_clk),
      .i_rst_n   (SYS_rst_n),
      .i_push0   (w_push0),
      .i_entry0  ('{addr: WBA_addr, data: WBA_data}),
      .i_push1   (w_push1),
      .i_entry1  ('{addr: WBB_addr, data: WBB_data}),
      .i_pop     (w_pop),
      .o_head    (w_head),
      .o_count   (w_count),
      .o_entries (w_entries)
   );

   assign REG_write_1     = w_nonempty;
   assign REG_address_wr  = w_nonempty ? w_head.addr : '0;
   assign REG_data_wb_in1 = w_nonempty ? w_head.data : '0;
   assign WB_count        = w_count;
   assign WB_empty        = !w_nonempty;

`ifdef REG_WB_QUEUE_FWD_EN
   // Scan oldest to youngest so the youngest matching entry wins.
   always_comb begin
      FWD_hit1  = 1'b0;
      FWD_data1 = '0;
      FWD_hit2  = 1'b0;
      FWD_data2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < w_count) begin
            if (FWD_addr1 != REG_ZERO && w_entries[i].addr == FWD_addr1) begin
               FWD_hit1  = 1'b1;
               FWD_data1 = w_entries[i].data;
            end
            if (FWD_addr2 != REG_ZERO && w_entries[i].addr == FWD_addr2) begin
               FWD_hit2  = 1'b1;
               FWD_data2 = w_entries[i].data;
            end
         end
      end
   end
`else
   logic w_unused_fwd;
   assign w_unused_fwd = ^{FWD_addr1, FWD_addr2, w_entries};
   assign FWD_hit1     = 1'b0;
   assign FWD_data1    = '0;
   assign FWD_hit2     = 1'b0;
   assign FWD_data2    = '0;
`endif

endmodule
